// File: rtl/atctlc2axi500_wr_split.sv
// Write-request splitter: turns a beat stream (header fields on the first beat) into
// AXI AW + W bursts, limits outstanding writes and retires B responses.
module atctlc2axi500_wr_split #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IDW     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic [IDW-1:0]    req_id,
  input  logic [7:0]        req_len,
  input  logic [DW-1:0]     req_data,
  input  logic [DW/8-1:0]   req_strb,
  output logic              awvalid,
  input  logic              awready,
  output logic [AW-1:0]     awaddr,
  output logic [IDW-1:0]    awid,
  output logic [7:0]        awlen,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DW-1:0]     wdata,
  output logic [DW/8-1:0]   wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              err_o,
  output logic              idle_o
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {HDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [7:0]    beat_cnt, beat_cnt_nxt;
  logic [7:0]    len_q, len_nxt;
  logic [CW-1:0] out_cnt;
  logic          full, aw_hs, w_hs, b_orphan;
  logic          unused_ok;

  // Header fields come straight from the FIFO head; it is not popped in HDR, so they hold.
  assign awaddr    = req_addr;
  assign awid      = req_id;
  assign awlen     = req_len;
  assign awburst   = 2'b01;
  assign wdata     = req_data;
  assign wstrb     = req_strb;
  assign bready    = 1'b1;
  assign unused_ok = bresp[0];

  assign full     = (out_cnt >= CW'(MAX_OUT));
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign b_orphan = bvalid & (out_cnt == '0);
  assign idle_o   = (state == HDR) & (out_cnt == '0);

  // NOTE: every output and next-state variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    len_nxt      = len_q;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wlast        = 1'b0;
    req_ready    = 1'b0;
    unique case (state)
      HDR: begin
        awvalid = req_valid & ~full;
        if (awvalid && awready) begin
          len_nxt      = req_len;
          beat_cnt_nxt = 8'd0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        wvalid    = req_valid;
        req_ready = wready;
        wlast     = (beat_cnt == len_q);
        if (wvalid && wready) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          if (wlast) begin
            beat_cnt_nxt = 8'd0;
            state_nxt    = HDR;
          end
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HDR;
      beat_cnt <= 8'd0;
      len_q    <= 8'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      len_q    <= len_nxt;
    end
  end

  // A B arriving with nothing outstanding is a protocol violation: hold at zero and flag it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      unique case ({aw_hs, bvalid})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
      err_o <= bvalid & (bresp[1] | b_orphan);
    end
  end

endmodule
